pipelined_mod_adder_tree: RTL

- Successor to the polynomial-multiplier adder tree. Sums INPUTS_NUM coefficient terms per beat through a registered binary tree.
- Optionally reduces modulo MODULUS at every node, which keeps HE coefficients in range.
- Optionally accumulates tree results over a multi-beat packet, for inner products longer than the lane count.
- Full valid/ready handshake with backpressure on both sides; sits between the coefficient multipliers and the result buffer.

---
 rtl/adder_tree_pkg.sv | 49 ++++
 rtl/pipelined_mod_adder_tree_mod_adder.sv | 19 +
 rtl/pipelined_mod_adder_tree.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared definitions for the pipelined modular adder tree.
//   - width/latency helper functions used to size ports and tree levels
//   - mod_add: unsigned add with optional single conditional subtract of q
//   - acc_state_t: accumulator FSM states
package adder_tree_pkg;

  // Width used inside mod_add; callers cast operands in and the result out.
  localparam int MATH_W = 64;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  function automatic int stages_f(input int inputs_num);
    return $clog2(inputs_num);
  endfunction

  function automatic int latency_f(input int inputs_num, input int reg_every);
    return (stages_f(inputs_num) + reg_every - 1) / reg_every;
  endfunction

  // Data width carried at a given tree level (level 0 = input lanes).
  function automatic int level_width_f(input int idata_width, input int level, input bit mod_en);
    return mod_en ? idata_width : idata_width + level;
  endfunction

  function automatic int odata_width_f(input int idata_width, input int inputs_num,
                                       input int max_beats, input bit mod_en);
    return mod_en ? idata_width : idata_width + stages_f(inputs_num) + $clog2(max_beats);
  endfunction

  // A level is registered every reg_every stages, and the final level always is.
  function automatic bit is_reg_level_f(input int level, input int stages, input int reg_every);
    return ((level % reg_every) == 0) || (level == stages);
  endfunction

  // Both operands are assumed < q when mod_en is set, so one subtract suffices.
  function automatic logic [MATH_W-1:0] mod_add(input logic [MATH_W-1:0] a,
                                                input logic [MATH_W-1:0] b,
                                                input logic [MATH_W-1:0] q,
                                                input logic              mod_en);
    logic [MATH_W-1:0] s;
    s = a + b;
    if (mod_en && (s >= q)) s = s - q;
    return s;
  endfunction

endpackage

// File: rtl/pipelined_mod_adder_tree_mod_adder.sv
// Combinational two-input adder, optionally reduced modulo MODULUS.
// Ports:
//   a_i, b_i : operands (WIDTH bits, must be < MODULUS when MOD_EN=1)
//   y_o      : sum (WIDTH bits); callers size WIDTH to hold the grown sum when MOD_EN=0
module mod_adder
  import adder_tree_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter bit MOD_EN  = 1'b1,
  parameter int MODULUS = 12289
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = WIDTH'(mod_add(MATH_W'(a_i), MATH_W'(b_i), MATH_W'(MODULUS), MOD_EN));

endmodule

// File: rtl/pipelined_mod_adder_tree.sv
// Pipelined binary adder tree with optional modular reduction at every node
// and a multi-beat packet accumulator.
// Ports:
//   clk, nrst     : clock, synchronous active-low reset
//   in_valid/in_ready/in_last/idata : input beat handshake, packet end flag, packed lanes
//   out_valid/out_ready             : result handshake
//   odata         : packet sum
//   out_beats     : number of beats summed into odata
//   out_overflow  : packet was closed at MAX_BEATS without in_last
//
// Accumulator FSM
//   state | meaning
//   IDLE  | no partial sum held; next tree result starts a packet
//   ACCUM | acc_q/beats_q hold a partial packet sum
module pipelined_mod_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int INPUTS_NUM  = 128,
  parameter int IDATA_WIDTH = 14,
  parameter bit MOD_EN      = 1'b1,
  parameter int MODULUS     = 12289,
  parameter int REG_EVERY   = 1,
  parameter int MAX_BEATS   = 16
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [INPUTS_NUM*IDATA_WIDTH-1:0]     idata,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [odata_width_f(IDATA_WIDTH, INPUTS_NUM, MAX_BEATS, MOD_EN)-1:0] odata,
  output logic [$clog2(MAX_BEATS):0]            out_beats,
  output logic                                  out_overflow
);

  localparam int STAGES_NUM  = stages_f(INPUTS_NUM);
  localparam int ODATA_WIDTH = odata_width_f(IDATA_WIDTH, INPUTS_NUM, MAX_BEATS, MOD_EN);
  localparam int PAD_NUM     = 1 << STAGES_NUM;
  localparam int TREE_WIDTH  = level_width_f(IDATA_WIDTH, STAGES_NUM, MOD_EN);
  localparam int BEATS_WIDTH = $clog2(MAX_BEATS) + 1;
  localparam logic [BEATS_WIDTH-1:0] BEATS_MAX = BEATS_WIDTH'(MAX_BEATS);

  logic adv;
  logic out_valid_q, out_valid_d;

  // The whole pipeline, accumulator included, moves as one shift chain.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & nrst;

  // Each level carries data, valid and last. Levels that are not registered
  // pass their adders straight through to the next level.
  for (genvar k = 0; k <= STAGES_NUM; k++) begin : g_lvl
    localparam int NN = PAD_NUM >> k;
    localparam int WK = level_width_f(IDATA_WIDTH, k, MOD_EN);
    logic [WK-1:0] dat [NN];
    logic          vld;
    logic          lst;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < PAD_NUM; i++) begin : g_lane
        if (i < INPUTS_NUM) begin : g_real
          assign dat[i] = idata[i*IDATA_WIDTH +: IDATA_WIDTH];
        end else begin : g_pad
          assign dat[i] = '0;
        end
      end
      assign vld = in_valid & in_ready;
      assign lst = in_last;
    end else begin : g_node
      logic [WK-1:0] sum [NN];
      for (genvar j = 0; j < NN; j++) begin : g_add
        mod_adder #(
          .WIDTH  (WK),
          .MOD_EN (MOD_EN),
          .MODULUS(MODULUS)
        ) u_add (
          .a_i(WK'(g_lvl[k-1].dat[2*j])),
          .b_i(WK'(g_lvl[k-1].dat[2*j+1])),
          .y_o(sum[j])
        );
      end

      if (is_reg_level_f(k, STAGES_NUM, REG_EVERY)) begin : g_reg
        logic [WK-1:0] dat_q [NN];
        logic          vld_q;
        logic          lst_q;

        always_ff @(posedge clk) begin
          if (!nrst) begin
            vld_q <= 1'b0;
          end else if (adv) begin
            vld_q <= g_lvl[k-1].vld;
          end
        end

        // Data needs no reset; it is qualified by vld_q.
        always_ff @(posedge clk) begin
          if (adv) begin
            dat_q <= sum;
            lst_q <= g_lvl[k-1].lst;
          end
        end

        assign dat = dat_q;
        assign vld = vld_q;
        assign lst = lst_q;
      end else begin : g_comb
        assign dat = sum;
        assign vld = g_lvl[k-1].vld;
        assign lst = g_lvl[k-1].lst;
      end
    end
  end

  logic [TREE_WIDTH-1:0] tree_res;
  logic                  tree_vld;
  logic                  tree_last;

  assign tree_res  = g_lvl[STAGES_NUM].dat[0];
  assign tree_vld  = g_lvl[STAGES_NUM].vld;
  assign tree_last = g_lvl[STAGES_NUM].lst;

  acc_state_t              state_q, state_d;
  logic [ODATA_WIDTH-1:0]  acc_q, acc_d;
  logic [BEATS_WIDTH-1:0]  beats_q, beats_d;
  logic [ODATA_WIDTH-1:0]  odata_q, odata_d;
  logic [BEATS_WIDTH-1:0]  out_beats_q, out_beats_d;
  logic                    out_ovf_q, out_ovf_d;

  logic [ODATA_WIDTH-1:0]  acc_base;
  logic [ODATA_WIDTH-1:0]  acc_sum;
  logic [BEATS_WIDTH-1:0]  beats_inc;
  logic                    fire;
  logic                    close;

  assign acc_base  = (state_q == ACCUM) ? acc_q : '0;
  assign beats_inc = ((state_q == ACCUM) ? beats_q : '0) + BEATS_WIDTH'(1);
  assign fire      = adv & tree_vld;
  assign close     = tree_last | (beats_inc == BEATS_MAX);

  mod_adder #(
    .WIDTH  (ODATA_WIDTH),
    .MOD_EN (MOD_EN),
    .MODULUS(MODULUS)
  ) u_acc_add (
    .a_i(acc_base),
    .b_i(ODATA_WIDTH'(tree_res)),
    .y_o(acc_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    odata_d     = odata_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      odata_d     = '0;
      out_beats_d = '0;
      out_ovf_d   = 1'b0;
    end

    if (fire) begin
      if (close) begin
        out_valid_d = 1'b1;
        odata_d     = acc_sum;
        out_beats_d = beats_inc;
        // Closing without in_last can only mean the beat limit was hit.
        out_ovf_d   = ~tree_last;
        state_d     = IDLE;
        acc_d       = '0;
        beats_d     = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_sum;
        beats_d = beats_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      odata_q     <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      odata_q     <= odata_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign odata        = odata_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

endmodule
